// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - doubleword load/store responder with a fixed-latency register-array memory
module dmem_lsu #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [60:0] DEPTH_W   = 61'(DEPTH);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [2:0]  F3_DWORD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  op_q, op_d;
    logic [2:0]  f3_q, f3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [63:0] mem_q [DEPTH];
    logic [63:0] mem_d [DEPTH];

    logic             is_load;
    logic             is_store;
    logic             aligned;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign is_load   = (op_q == OP_LOAD)  && (f3_q == F3_DWORD);
    assign is_store  = (op_q == OP_STORE) && (f3_q == F3_DWORD);
    assign aligned   = (addr_q[2:0] == 3'b000);
    assign in_range  = (addr_q[63:3] < DEPTH_W);
    assign idx       = addr_q[3 +: IDX_W];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rdata     = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = opcode;
                    f3_d    = func3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    // Memory is touched only on this edge, so a reset in WAIT loses the store.
                    if (is_load && aligned && in_range) begin
                        rdata_d = mem_q[idx];
                        err_d   = 1'b0;
                    end else if (is_store && aligned && in_range) begin
                        mem_d[idx] = wdata_q;
                        rdata_d    = 64'd0;
                        err_d      = 1'b0;
                    end else begin
                        rdata_d = 64'd0;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 7'd0;
            f3_q    <= 3'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rdata;
    logic        rsp_err;

    int total = 0;
    int bad = 0;

    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        rdy_low_seen;

    dmem_lsu #(.DEPTH(32), .LATENCY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opcode    (opcode),
        .func3     (func3),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [6:0] op, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] r, output logic e, output int l,
                          output logic busy_ok);
        req_valid = 1'b1;
        opcode    = op;
        func3     = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        l = 0;
        busy_ok = 1'b1;
        while (!rsp_valid && l < 50) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            l++;
        end
        check("rsp_valid_arrives", rsp_valid, 1'b1);
        r = rdata;
        e = rsp_err;
        if (rsp_ready) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rdata", rdata, 64'd0);
        check("reset_rsp_err", rsp_err, 1'b0);
        #13;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(OP_SD, 3'b011, 64'h10, 64'hDEADBEEF_CAFEF00D, rd, er, lat, rdy_low_seen);
        check("sd10_rdata", rd, 64'd0);
        check("sd10_err", er, 1'b0);
        check("sd10_latency", lat, 2);
        check("sd10_req_ready_low", rdy_low_seen, 1'b1);
        check("post_hs_idle", req_ready, 1'b1);
        check("post_hs_rsp_valid", rsp_valid, 1'b0);
        do_req(OP_LD, 3'b011, 64'h10, 64'h0, rd, er, lat, rdy_low_seen);
        check("ld10_rdata", rd, 64'hDEADBEEF_CAFEF00D);
        check("ld10_err", er, 1'b0);
        check("ld10_latency", lat, 2);
        check("ld10_rdata_kept", rdata, 64'hDEADBEEF_CAFEF00D);

        do_req(OP_LD, 3'b011, 64'h13, 64'h0, rd, er, lat, rdy_low_seen);
        check("ld13_err", er, 1'b1);
        check("ld13_rdata", rd, 64'd0);
        do_req(OP_SD, 3'b011, 64'h100, 64'h1234_5678_9ABC_DEF0, rd, er, lat, rdy_low_seen);
        check("sd100_err", er, 1'b1);
        check("sd100_rdata", rd, 64'd0);
        do_req(OP_SD, 3'b011, 64'hF8, 64'hA5A5, rd, er, lat, rdy_low_seen);
        check("sdF8_err", er, 1'b0);
        do_req(OP_LD, 3'b011, 64'h100, 64'h0, rd, er, lat, rdy_low_seen);
        check("ld100_err", er, 1'b1);
        check("ld100_rdata", rd, 64'd0);
        do_req(OP_LD, 3'b011, 64'hF8, 64'h0, rd, er, lat, rdy_low_seen);
        check("ldF8_rdata", rd, 64'hA5A5);
        check("ldF8_err", er, 1'b0);

        do_req(OP_LD, 3'b010, 64'h10, 64'h0, rd, er, lat, rdy_low_seen);
        check("ld_f3_010_err", er, 1'b1);
        check("ld_f3_010_rdata", rd, 64'd0);
        do_req(OP_ALU, 3'b011, 64'h10, 64'h1111, rd, er, lat, rdy_low_seen);
        check("alu_err", er, 1'b1);
        do_req(OP_SD, 3'b010, 64'h10, 64'h2222, rd, er, lat, rdy_low_seen);
        check("sd_f3_010_err", er, 1'b1);
        do_req(OP_LD, 3'b011, 64'h10, 64'h0, rd, er, lat, rdy_low_seen);
        check("ld10_unchanged", rd, 64'hDEADBEEF_CAFEF00D);
        check("ld10_unchanged_err", er, 1'b0);

        rsp_ready = 1'b0;
        do_req(OP_LD, 3'b011, 64'h10, 64'h0, rd, er, lat, rdy_low_seen);
        check("bp_first_rdata", rd, 64'hDEADBEEF_CAFEF00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
            check("bp_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_rsp_valid", rsp_valid, 1'b0);
        check("bp_release_req_ready", req_ready, 1'b1);

        req_valid = 1'b1;
        opcode    = OP_SD;
        func3     = 3'b011;
        addr      = 64'h8;
        wdata     = 64'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wait_req_ready", req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_ready", req_ready, 1'b1);
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check("rst_mid_rdata", rdata, 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(OP_LD, 3'b011, 64'h8, 64'h0, rd, er, lat, rdy_low_seen);
        check("ld8_after_rst", rd, 64'd0);
        check("ld8_after_rst_err", er, 1'b0);
        do_req(OP_LD, 3'b011, 64'h10, 64'h0, rd, er, lat, rdy_low_seen);
        check("ld10_after_rst", rd, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
